// File: rtl/rv_pkg.sv
// Shared types for the RV32I decode/execute stage: opcodes, ALU operations,
// operand selects and the registered control bundle.
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // ALU_ADD is zero so an all-zero bundle is a harmless NOP
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
    } alu_op_e;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic       {B_RS2, B_IMM} b_sel_e;

    typedef struct packed {
        alu_op_e     alu_op;
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_write;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } control_info;

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU with compare flags; the multiply ops are only
// built when RV_MUL_EN is defined.
module rv_alu
    import rv_pkg::*;
(
    input  alu_op_e     alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

`ifdef RV_MUL_EN
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    // One 64-bit multiplier; the operand extension picks signedness
    always_comb begin
        mul_a = {32'b0, a};
        mul_b = {32'b0, b};
        if (alu_op == ALU_MULH || alu_op == ALU_MULHSU) begin
            mul_a = {{32{a[31]}}, a};
        end
        if (alu_op == ALU_MULH) begin
            mul_b = {{32{b[31]}}, b};
        end
    end

    assign prod = mul_a * mul_b;
`endif

    always_comb begin
        result = 32'b0;
        case (alu_op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'b0, lt};
            ALU_SLTU:   result = {31'b0, ltu};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $signed(a) >>> b[4:0];
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASSB:  result = b;
`ifdef RV_MUL_EN
            ALU_MUL:    result = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result = prod[63:32];
`endif
            default:    result = 32'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_exec.sv
// RV32I decode + execute stage: combinational register indices, a registered
// control bundle, then a registered result/next-PC. RV_MUL_EN adds MUL/MULH*.
module rv32i_decode_exec
    import rv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESET_PC_INC = 4
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [31:0]     INSTRUCTION,
    input  logic [XLEN-1:0] PC,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    output control_info     CTR_INFO,
    input  logic [XLEN-1:0] RS1_VAL,
    input  logic [XLEN-1:0] RS2_VAL,
    output logic [XLEN-1:0] EXEC_RESULT,
    output logic [XLEN-1:0] NEXT_PC,
    output logic            BRANCH_TAKEN
);

    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;
    control_info ctr_d;

    assign RS1 = INSTRUCTION[19:15];
    assign RS2 = INSTRUCTION[24:20];

    assign opc = INSTRUCTION[6:0];
    assign rd  = INSTRUCTION[11:7];
    assign f3  = INSTRUCTION[14:12];
    assign f7  = INSTRUCTION[31:25];

    assign imm_i = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_s = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign imm_b = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                    INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
    assign imm_u = {INSTRUCTION[31:12], 12'b0};
    assign imm_j = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

    always_comb begin
        ctr_d        = '0;
        ill          = 1'b0;
        ctr_d.pc     = PC;
        ctr_d.rd     = rd;
        ctr_d.funct3 = f3;
        case (opc)
            OP: begin
                ctr_d.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    ctr_d.alu_op = base_alu_op(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    ctr_d.alu_op = base_alu_op(f3, 1'b1);
`ifdef RV_MUL_EN
                end else if (f7 == F7_MUL && !f3[2]) begin
                    case (f3[1:0])
                        2'b00:   ctr_d.alu_op = ALU_MUL;
                        2'b01:   ctr_d.alu_op = ALU_MULH;
                        2'b10:   ctr_d.alu_op = ALU_MULHSU;
                        default: ctr_d.alu_op = ALU_MULHU;
                    endcase
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            OP_IMM: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.b_sel     = B_IMM;
                ctr_d.imm       = imm_i;
                // Shift-immediates reuse the funct7 field; imm[10] picks SRAI
                if (f3 == 3'b001 && f7 != F7_BASE) begin
                    ill = 1'b1;
                end else if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) begin
                    ill = 1'b1;
                end
                ctr_d.alu_op = base_alu_op(f3, (f3 == 3'b101) && imm_i[10]);
            end
            LUI: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.a_sel     = A_ZERO;
                ctr_d.b_sel     = B_IMM;
                ctr_d.alu_op    = ALU_PASSB;
                ctr_d.imm       = imm_u;
            end
            AUIPC: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.a_sel     = A_PC;
                ctr_d.b_sel     = B_IMM;
                ctr_d.imm       = imm_u;
            end
            JAL: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.is_jal    = 1'b1;
                ctr_d.a_sel     = A_PC;
                ctr_d.b_sel     = B_IMM;
                ctr_d.imm       = imm_j;
            end
            JALR: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.is_jalr   = 1'b1;
                ctr_d.b_sel     = B_IMM;
                ctr_d.imm       = imm_i;
            end
            BRANCH: begin
                ctr_d.is_branch = 1'b1;
                ctr_d.imm       = imm_b;
                ill             = (f3[2:1] == 2'b01);
            end
            LOAD: begin
                ctr_d.reg_write = 1'b1;
                ctr_d.is_load   = 1'b1;
                ctr_d.b_sel     = B_IMM;
                ctr_d.imm       = imm_i;
            end
            STORE: begin
                ctr_d.is_store = 1'b1;
                ctr_d.b_sel    = B_IMM;
                ctr_d.imm      = imm_s;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctr_d         = '0;
            ctr_d.pc      = PC;
            ctr_d.illegal = 1'b1;
        end else if (rd == 5'd0) begin
            ctr_d.reg_write = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            CTR_INFO <= '0;
        end else begin
            CTR_INFO <= ctr_d;
        end
    end

    // Execute: operates on the bundle captured at the previous edge
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [XLEN-1:0] seq_pc, br_target;
    logic [XLEN-1:0] res_d, npc_d;
    logic            taken_d, br_cond;
    logic            eq, lt, ltu;

    always_comb begin
        case (CTR_INFO.a_sel)
            A_RS1:   alu_a = RS1_VAL;
            A_PC:    alu_a = CTR_INFO.pc;
            default: alu_a = '0;
        endcase
        alu_b = (CTR_INFO.b_sel == B_IMM) ? CTR_INFO.imm : RS2_VAL;
    end

    rv_alu u_alu (
        .alu_op (CTR_INFO.alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .eq     (eq),
        .lt     (lt),
        .ltu    (ltu)
    );

    assign seq_pc    = CTR_INFO.pc + XLEN'(RESET_PC_INC);
    assign br_target = CTR_INFO.pc + CTR_INFO.imm;

    always_comb begin
        case (CTR_INFO.funct3)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = !lt;
            3'b110:  br_cond = ltu;
            3'b111:  br_cond = !ltu;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        res_d   = alu_res;
        npc_d   = seq_pc;
        taken_d = 1'b0;
        if (CTR_INFO.illegal) begin
            res_d = '0;
        end else if (CTR_INFO.is_jal) begin
            res_d   = seq_pc;
            npc_d   = alu_res;
            taken_d = 1'b1;
        end else if (CTR_INFO.is_jalr) begin
            res_d   = seq_pc;
            npc_d   = {alu_res[XLEN-1:1], 1'b0};
            taken_d = 1'b1;
        end else if (CTR_INFO.is_branch) begin
            res_d = '0;
            if (br_cond) begin
                npc_d   = br_target;
                taken_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            EXEC_RESULT  <= '0;
            NEXT_PC      <= '0;
            BRANCH_TAKEN <= 1'b0;
        end else begin
            EXEC_RESULT  <= res_d;
            NEXT_PC      <= npc_d;
            BRANCH_TAKEN <= taken_d;
        end
    end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Bench for rv32i_decode_exec: directed cases plus random instructions
// checked against a behavioural RV32I model (honours RV_MUL_EN).
module tb_rv32i_decode_exec;
    import rv_pkg::*;

    logic        CLK;
    logic        RSTN;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    control_info CTR_INFO;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic [31:0] EXEC_RESULT;
    logic [31:0] NEXT_PC;
    logic        BRANCH_TAKEN;

    int n_total = 0;
    int n_bad   = 0;

`ifdef RV_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    rv32i_decode_exec dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .INSTRUCTION  (INSTRUCTION),
        .PC           (PC),
        .RS1          (RS1),
        .RS2          (RS2),
        .CTR_INFO     (CTR_INFO),
        .RS1_VAL      (RS1_VAL),
        .RS2_VAL      (RS2_VAL),
        .EXEC_RESULT  (EXEC_RESULT),
        .NEXT_PC      (NEXT_PC),
        .BRANCH_TAKEN (BRANCH_TAKEN)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // encoders
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // behavioural reference
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] x, input logic [31:0] y);
        int sh = int'(y % 32);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'(longint'($signed(x)) >>> sh) : x >> sh;
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        case (f3)
            3'd0: return 32'(ux * uy);
            3'd1: return 32'((sx * sy) >>> 32);
            3'd2: return 32'((sx * longint'(uy)) >>> 32);
            default: return 32'((ux * uy) >> 32);
        endcase
    endfunction

    task automatic model(input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] npc,
                         output logic tk, output logic wr, output logic ill);
        logic [6:0]  opc = ins[6:0];
        logic [6:0]  f7  = ins[31:25];
        logic [2:0]  f3  = ins[14:12];
        logic [31:0] ii  = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] iu  = {ins[31:12], 12'b0};
        logic [31:0] ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic        cond;
        res = 32'd0; npc = pcv + 32'd4; tk = 1'b0; wr = 1'b0; ill = 1'b0;
        case (opc)
            7'h33: begin
                wr = 1'b1;
                if (f7 == 7'h00) res = ref_alu(f3, 1'b0, a, b);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) res = ref_alu(f3, 1'b1, a, b);
                else if (f7 == 7'h01 && f3 < 3'd4 && MUL_ON) res = ref_mul(f3, a, b);
                else ill = 1'b1;
            end
            7'h13: begin
                wr = 1'b1;
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
                else res = ref_alu(f3, f3 == 3'd5 && ins[30], a, ii);
            end
            7'h37: begin wr = 1'b1; res = iu; end
            7'h17: begin wr = 1'b1; res = pcv + iu; end
            7'h6F: begin wr = 1'b1; res = pcv + 32'd4; npc = pcv + ij; tk = 1'b1; end
            7'h67: begin wr = 1'b1; res = pcv + 32'd4; npc = (a + ii) & ~32'd1; tk = 1'b1; end
            7'h63: begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = ($signed(a) < $signed(b));
                    3'd5: cond = ($signed(a) >= $signed(b));
                    3'd6: cond = (a < b);
                    3'd7: cond = (a >= b);
                    default: begin cond = 1'b0; ill = 1'b1; end
                endcase
                if (cond) begin npc = pcv + ib; tk = 1'b1; end
            end
            7'h03: begin wr = 1'b1; res = a + ii; end
            7'h23: res = a + is;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            res = 32'd0; npc = pcv + 32'd4; tk = 1'b0; wr = 1'b0;
        end
        if (ins[11:7] == 5'd0) wr = 1'b0;
    endtask

    // driver: one decode edge, then one execute edge
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] pcv,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_res, e_npc;
        logic        e_tk, e_wr, e_ill;
        @(negedge CLK);
        INSTRUCTION = ins; PC = pcv; RS1_VAL = a; RS2_VAL = b;
        #1;
        check("rs1", {27'b0, RS1}, {27'b0, ins[19:15]});
        check("rs2", {27'b0, RS2}, {27'b0, ins[24:20]});
        model(ins, pcv, a, b, e_res, e_npc, e_tk, e_wr, e_ill);
        @(posedge CLK); #1;
        check("reg_write", {31'b0, CTR_INFO.reg_write}, {31'b0, e_wr});
        check("illegal", {31'b0, CTR_INFO.illegal}, {31'b0, e_ill});
        if (e_wr) check("rd", {27'b0, CTR_INFO.rd}, {27'b0, ins[11:7]});
        @(posedge CLK); #1;
        check("result", EXEC_RESULT, e_res);
        check("next_pc", NEXT_PC, e_npc);
        check("taken", {31'b0, BRANCH_TAKEN}, {31'b0, e_tk});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctr"}, {31'b0, |CTR_INFO}, 32'd0);
        check({tag, "_res"}, EXEC_RESULT, 32'd0);
        check({tag, "_npc"}, NEXT_PC, 32'd0);
        check({tag, "_tk"}, {31'b0, BRANCH_TAKEN}, 32'd0);
    endtask

    logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};

    initial begin
        logic [31:0] v, ins, a, b;
        RSTN = 1'b0; INSTRUCTION = 32'h0000_0013; PC = 32'd0; RS1_VAL = 32'd0; RS2_VAL = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RSTN = 1'b1;

        // ADD x3,x3,x2 with result fed back as rs1
        v = 32'd1;
        for (int i = 0; i < 11; i++) begin
            run_instr(32'h002181B3, 32'h0, v, 32'd2);
            v = v + 32'd2;
        end
        check("add_chain", EXEC_RESULT, 32'd23);
        run_instr(32'h002182B3, 32'h4, 32'd23, 32'd2);
        check("add_rd5", {27'b0, CTR_INFO.rd}, 32'd5);
        check("add_25", EXEC_RESULT, 32'd25);

        run_instr(r_type(7'h20, 5'd7, 5'd5, 3'd0, 5'd1), 32'h8, 32'd5, 32'd7);
        check("sub", EXEC_RESULT, 32'hFFFF_FFFE);
        run_instr(r_type(7'h20, 5'd2, 5'd1, 3'd5, 5'd1), 32'hC, 32'h8000_0000, 32'd4);
        check("sra", EXEC_RESULT, 32'hF800_0000);
        run_instr(r_type(7'h00, 5'd2, 5'd1, 3'd5, 5'd1), 32'hC, 32'h8000_0000, 32'd4);
        check("srl", EXEC_RESULT, 32'h0800_0000);

        run_instr(32'hFFF0_0093, 32'h10, 32'd0, 32'd0);
        check("addi_imm", CTR_INFO.imm, 32'hFFFF_FFFF);
        check("addi_res", EXEC_RESULT, 32'hFFFF_FFFF);
        run_instr(i_type(12'd1, 5'd0, 3'd3, 5'd1, 7'h13), 32'h14, 32'd0, 32'd0);
        check("sltiu", EXEC_RESULT, 32'd1);
        run_instr(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h18, 32'd1, 32'd1);
        check("add_x0_wr", {31'b0, CTR_INFO.reg_write}, 32'd0);

        run_instr(b_type(13'd8, 5'd2, 5'd1, 3'd4), 32'h100, 32'hFFFF_FFFF, 32'd1);
        check("blt_tk", {31'b0, BRANCH_TAKEN}, 32'd1);
        check("blt_npc", NEXT_PC, 32'h108);
        check("blt_wr", {31'b0, CTR_INFO.reg_write}, 32'd0);
        run_instr(b_type(13'd8, 5'd2, 5'd1, 3'd6), 32'h100, 32'hFFFF_FFFF, 32'd1);
        check("bltu_tk", {31'b0, BRANCH_TAKEN}, 32'd0);
        check("bltu_npc", NEXT_PC, 32'h104);

        run_instr(j_type(21'd16, 5'd1), 32'h40, 32'd0, 32'd0);
        check("jal_res", EXEC_RESULT, 32'h44);
        check("jal_npc", NEXT_PC, 32'h50);
        run_instr(i_type(12'd0, 5'd3, 3'd0, 5'd1, 7'h67), 32'h80, 32'h203, 32'd0);
        check("jalr_npc", NEXT_PC, 32'h202);
        check("jalr_res", EXEC_RESULT, 32'h84);

        run_instr(32'h0000_007F, 32'h90, 32'd9, 32'd9);
        check("ill_flag", {31'b0, CTR_INFO.illegal}, 32'd1);
        check("ill_wr", {31'b0, CTR_INFO.reg_write}, 32'd0);
        check("ill_res", EXEC_RESULT, 32'd0);

        run_instr(32'h0220_8033, 32'hA0, 32'd3, 32'd5);
        check("mul_res", EXEC_RESULT, MUL_ON ? 32'd15 : 32'd0);
        check("mul_ill", {31'b0, CTR_INFO.illegal}, MUL_ON ? 32'd0 : 32'd1);

        // asynchronous reset between edges, then recovery
        @(negedge CLK);
        INSTRUCTION = 32'h002181B3; PC = 32'h200; RS1_VAL = 32'd4; RS2_VAL = 32'd6;
        @(posedge CLK); #2;
        RSTN = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge CLK);
        RSTN = 1'b1;
        run_instr(32'h002181B3, 32'h200, 32'd4, 32'd6);
        check("recover", EXEC_RESULT, 32'd10);

        // random stimulus
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(ins, 32'($urandom_range(0, 262143)) << 2, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_exec.md
Name: rv32i_decode_exec

Overview:
- Combined RV32I instruction decoder and integer execute stage for the multi-cycle core (fetch -> decode -> execute -> write).
- Decodes the fetched instruction into register indices and a registered control bundle.
- Computes a registered result, branch decision and next PC from operand values read by the core's register file.
- Owns no register file and no memory; the core latches operands and performs the writeback.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RESET_PC_INC, 4, PC increment for sequential flow (byte addressing).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  reset.
- INSTRUCTION  in  32  instruction word, held stable by the core from fetch until the next fetch.
- PC  in  32  byte address of INSTRUCTION.
- RS1  out  5  INSTRUCTION[19:15], combinational.
- RS2  out  5  INSTRUCTION[24:20], combinational.
- CTR_INFO  out  control_info  registered decode bundle.
- RS1_VAL  in  32  value of register RS1, supplied by the core.
- RS2_VAL  in  32  value of register RS2, supplied by the core.
- EXEC_RESULT  out  32  registered result.
- NEXT_PC  out  32  registered next PC.
- BRANCH_TAKEN  out  1  registered redirect flag.

Interface rule (already decided): one clock, CLK; reset RSTN is asynchronous and active-low.

Behaviour:
- Reset: while RSTN=0, all CTR_INFO fields, EXEC_RESULT, NEXT_PC and BRANCH_TAKEN are 0, with immediate (asynchronous) effect. A CTR_INFO of all zeros is a NOP (reg_write=0).
- Decode timing: RS1 and RS2 are combinational with zero latency. CTR_INFO is captured from INSTRUCTION and PC on every rising edge (latency 1, free-running, no enable).
- CTR_INFO fields:
  - alu_op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, plus MUL ops.
  - a_sel: RS1 / PC / zero. b_sel: RS2 / IMM.
  - rd, funct3, and imm (sign-extended per I/S/B/U/J format).
  - pc, reg_write, is_branch, is_jal, is_jalr, is_load, is_store, illegal.
- reg_write is forced to 0 when rd=0 or when the instruction is illegal.
- Execute timing: each rising edge registers EXEC_RESULT, NEXT_PC and BRANCH_TAKEN from the current CTR_INFO, RS1_VAL and RS2_VAL (latency 1 after CTR_INFO). In the core's 4-state loop, the result is valid at the write edge.
- Default outputs: NEXT_PC = pc+4, BRANCH_TAKEN = 0.
- Semantics by opcode:
  - OP: rs1 op rs2.
  - OP-IMM: rs1 op imm. Shift amount is imm[4:0]; SRAI is selected by imm[10].
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - JAL: result = pc+4, NEXT_PC = pc+imm, taken = 1.
  - JALR: result = pc+4, NEXT_PC = (rs1+imm) & ~1, taken = 1.
  - BRANCH (BEQ, BNE, BLT, BGE, BLTU, BGEU): result = 0; if taken, NEXT_PC = pc+imm and BRANCH_TAKEN = 1.
  - LOAD/STORE: result = rs1+imm (effective address). reg_write is 1 for loads, 0 for stores.
- Arithmetic: all wraps modulo 2^32. Register shifts use rs2[4:0]. SLT/BLT are signed; SLTU/BLTU are unsigned.
- Illegal instructions set illegal=1; result = 0, NEXT_PC = pc+4. Illegal cases:
  - unknown opcode;
  - funct7 other than 0000000, or 0100000 where SUB/SRA/SRAI apply;
  - branch funct3 010 or 011;
  - bit 25 set in shift-immediates.
- Reset deasserted mid-instruction: outputs recover on the next edge from the current inputs.

Optional Feature:
- Macro RV_MUL_EN.
- With it defined: OP with funct7=0000001 and funct3 000/001/010/011 executes MUL, MULH, MULHSU, MULHU (low word, or signed/signed-unsigned/unsigned high word), same latency.
- Without it: those encodings are illegal.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE);
  - alu_op_e enum;
  - a_sel/b_sel enums;
  - packed struct control_info.
- One sub-module, rv_alu: combinational, takes alu_op, a, b and returns result and compare flags. Instantiated once by the execute logic.

Test Plan:
- ADD x3,x3,x2 (0x002181B3): RS1=3, RS2=2 immediately; next edge rd=3, reg_write=1. With RS1_VAL=1 and RS2_VAL=2 -> EXEC_RESULT=3. Eleven feedback iterations -> 23. Then 0x002182B3 -> rd=5, result 25.
- SUB rs1=5, rs2=7 -> 0xFFFFFFFE. SRA 0x80000000 by 4 -> 0xF8000000. SRL same operands -> 0x08000000.
- ADDI x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF, result 0xFFFFFFFF. SLTIU with rs1=0, imm=1 -> 1. ADD with rd=0 -> reg_write=0.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=8 -> taken, NEXT_PC=0x108, reg_write=0. BLTU with the same values -> not taken, NEXT_PC=0x104.
- JAL x1,+16 at pc=0x40 -> result 0x44, NEXT_PC=0x50. JALR with rs1=0x203, imm=0 -> NEXT_PC=0x202, result pc+4.
- Fault and macro cases:
  - 0x0000007F -> illegal=1, reg_write=0.
  - RSTN low mid-execute -> all outputs 0 without a clock edge.
  - MUL 0x02208033 with 3*5 -> 15 under RV_MUL_EN, illegal without it.
